// File: rtl/uart_boot_loader.sv
// uart_boot_loader: pulls a length-prefixed program from the UART receiver,
// packs it into little-endian 32-bit words, writes them to instruction memory
// and releases the CPU from reset once the last word is stored.
module uart_boot_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              rx_ready,
    input  logic [7:0]        rx_data,
    output logic              ready_clr,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t            state, state_n;
    logic [15:0]       count, count_n;
    logic [1:0]        byte_idx, byte_idx_n;
    logic [ADDR_W:0]   word_idx, word_idx_n;
    logic [31:0]       word_buf, word_buf_n;

    logic              ready_clr_n;
    logic              imem_we_n;
    logic [ADDR_W-1:0] imem_addr_n;
    logic [31:0]       imem_wdata_n;
    logic              cpu_reset_n;
    logic              done_n;
    logic              error_n;

    logic              accept;
    logic [15:0]       hdr_count;
    logic [ADDR_W:0]   word_inc;

    // Next-state and next-output logic; every output is registered, so the
    // values computed here only appear on the ports one cycle later.
    always_comb begin
        state_n      = state;
        count_n      = count;
        byte_idx_n   = byte_idx;
        word_idx_n   = word_idx;
        word_buf_n   = word_buf;
        imem_we_n    = 1'b0;
        imem_addr_n  = imem_addr;
        imem_wdata_n = imem_wdata;
        cpu_reset_n  = cpu_reset;
        done_n       = done;
        error_n      = error;

        // A byte is only taken in a receiving state and never while the
        // previous acknowledge is still on the wire, so a held rx_ready
        // cannot be consumed twice.
        accept = ((state == HDR0) || (state == HDR1) || (state == DATA))
                 && rx_ready && !ready_clr;
        ready_clr_n = accept;

        hdr_count = {rx_data, count[7:0]};
        word_inc  = word_idx + {{ADDR_W{1'b0}}, 1'b1};

        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = HDR0;
                end
            end
            HDR0: begin
                if (accept) begin
                    count_n[7:0] = rx_data;
                    state_n      = HDR1;
                end
            end
            HDR1: begin
                if (accept) begin
                    count_n = hdr_count;
                    if ((hdr_count == 16'd0) ||
                        ({16'd0, hdr_count} > 32'(MAX_WORDS))) begin
                        state_n = ERROR;
                        error_n = 1'b1;
                    end else begin
                        state_n    = DATA;
                        byte_idx_n = 2'd0;
                        word_idx_n = '0;
                        word_buf_n = 32'd0;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    word_buf_n[{byte_idx, 3'b000} +: 8] = rx_data;
                    byte_idx_n = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        // Fourth byte: the write strobe goes out next cycle.
                        state_n      = WRITE;
                        imem_we_n    = 1'b1;
                        imem_addr_n  = word_idx[ADDR_W-1:0];
                        imem_wdata_n = {rx_data, word_buf[23:0]};
                    end
                end
            end
            WRITE: begin
                word_idx_n = word_inc;
                byte_idx_n = 2'd0;
                // Index is one bit wider than the address so a full-size
                // program compares against count without wrapping.
                if (32'(word_inc) == {16'd0, count}) begin
                    state_n     = DONE;
                    cpu_reset_n = 1'b0;
                    done_n      = 1'b1;
                end else begin
                    state_n = DATA;
                end
            end
            DONE: begin
                state_n = DONE;
            end
            ERROR: begin
                state_n = ERROR;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any partial word
    // and keeps the CPU held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= 16'd0;
            byte_idx   <= 2'd0;
            word_idx   <= '0;
            word_buf   <= 32'd0;
            ready_clr  <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'd0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            byte_idx   <= byte_idx_n;
            word_idx   <= word_idx_n;
            word_buf   <= word_buf_n;
            ready_clr  <= ready_clr_n;
            imem_we    <= imem_we_n;
            imem_addr  <= imem_addr_n;
            imem_wdata <= imem_wdata_n;
            cpu_reset  <= cpu_reset_n;
            done       <= done_n;
            error      <= error_n;
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Testbench for uart_boot_loader: a byte-queue receiver model feeds the DUT,
// a monitor records acks and writes, and a stream-level model predicts them.
module tb_uart_boot_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 256;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic              rx_ready;
    logic [7:0]        rx_data;
    logic              ready_clr;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    int checks   = 0;
    int failures = 0;

    // receiver contents and the copy handed to the model
    logic [7:0]        stream[$];
    logic [7:0]        sent[$];

    // observations
    int                ack_cyc[$];
    logic [ADDR_W-1:0] wr_addr[$];
    logic [31:0]       wr_data[$];
    int                wr_cyc[$];
    int                done_cyc, err_cyc, rel_cyc;
    int                dbl_clr, long_we, acks_before_enable;

    // model predictions
    int                exp_acks;
    logic              exp_done, exp_error;
    logic [31:0]       exp_words[$];

    uart_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .ready_clr  (ready_clr),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Predicts the load outcome from the byte stream alone: header length,
    // legality, how many bytes get consumed and which words get written.
    function automatic void run_model();
        int c, need;
        exp_words.delete();
        exp_done  = 1'b0;
        exp_error = 1'b0;
        if (sent.size() < 2) begin
            exp_acks = sent.size();
            return;
        end
        c = int'(sent[1]) * 256 + int'(sent[0]);
        if (c == 0 || c > MAX_WORDS) begin
            exp_error = 1'b1;
            exp_acks  = 2;
            return;
        end
        need     = 2 + 4 * c;
        exp_acks = (sent.size() < need) ? sent.size() : need;
        exp_done = (sent.size() >= need);
        for (int i = 0; 2 + 4 * i + 3 < exp_acks; i++)
            exp_words.push_back({sent[2+4*i+3], sent[2+4*i+2],
                                 sent[2+4*i+1], sent[2+4*i]});
    endfunction

    // Counts recorded writes that disagree with the model in data, address,
    // or timing (strobe must coincide with the ack of the word's last byte).
    function automatic int write_mismatches();
        int bad = 0;
        logic [ADDR_W-1:0] ea;
        for (int i = 0; i < wr_data.size() && i < exp_words.size(); i++) begin
            ea = i[ADDR_W-1:0];
            if (wr_data[i] !== exp_words[i] || wr_addr[i] !== ea) bad++;
            if (2 + 4 * i + 3 < ack_cyc.size() && wr_cyc[i] != ack_cyc[2+4*i+3]) bad++;
        end
        return bad;
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        enable   = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        stream.delete();
        sent.delete();
        ack_cyc.delete();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc = -1;
        err_cyc  = -1;
        rel_cyc  = -1;
        dbl_clr  = 0;
        long_we  = 0;
        acks_before_enable = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Plays the receiver for a fixed number of cycles: presents the queue
    // head, drops it one edge after seeing ready_clr, optionally idles.
    task automatic run_load(input int idle_cycles, input int gap_max, input int budget);
        logic clr_last = 1'b0;
        logic we_last  = 1'b0;
        int   gap      = 0;
        sent = stream;
        for (int cyc = 0; cyc < budget; cyc++) begin
            @(posedge clk);
            #1;
            if (ready_clr === 1'b1) begin
                if (clr_last) dbl_clr++;
                ack_cyc.push_back(cyc);
                if (cyc <= idle_cycles + 1) acks_before_enable++;
            end
            if (imem_we === 1'b1) begin
                if (we_last) long_we++;
                wr_addr.push_back(imem_addr);
                wr_data.push_back(imem_wdata);
                wr_cyc.push_back(cyc);
            end
            if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
            if (error === 1'b1 && err_cyc < 0) err_cyc = cyc;
            if (cpu_reset === 1'b0 && rel_cyc < 0) rel_cyc = cyc;

            enable = (cyc == idle_cycles);
            if (clr_last && stream.size() > 0) begin
                void'(stream.pop_front());
                gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            end
            if (gap > 0) begin
                rx_ready = 1'b0;
                gap--;
            end else begin
                rx_ready = (stream.size() > 0);
            end
            if (rx_ready) rx_data = stream[0];
            else          rx_data = 8'($urandom);
            clr_last = ready_clr;
            we_last  = imem_we;
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        enable   = 1'b0;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        #1;
        checks++;
        if ({ready_clr, imem_we, done, error, cpu_reset} !== 5'b00001) begin
            failures++;
            $display("[TB] FAIL reset_strobes: got %b expected 00001",
                     {ready_clr, imem_we, done, error, cpu_reset});
        end
        checks++;
        if ({imem_addr, imem_wdata} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_data: got addr %h wdata %h expected 0", imem_addr, imem_wdata);
        end
        do_reset();
    endtask

    task automatic test_normal_load();
        do_reset();
        stream = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(0, 0, 60);
        run_model();
        checks++;
        if (wr_data.size() != exp_words.size() || write_mismatches() != 0) begin
            failures++;
            $display("[TB] FAIL normal_writes: got %0d writes, %0d bad, expected %0d writes",
                     wr_data.size(), write_mismatches(), exp_words.size());
        end
        checks++;
        if (ack_cyc.size() != exp_acks) begin
            failures++;
            $display("[TB] FAIL normal_acks: got %0d expected %0d", ack_cyc.size(), exp_acks);
        end
        checks++;
        if (done !== exp_done || cpu_reset !== !exp_done || error !== 1'b0) begin
            failures++;
            $display("[TB] FAIL normal_final: got done=%b cpu_reset=%b error=%b expected done=1 cpu_reset=0 error=0",
                     done, cpu_reset, error);
        end
        checks++;
        if (wr_cyc.size() < 2 || done_cyc != wr_cyc[wr_cyc.size()-1] + 1 || rel_cyc != done_cyc) begin
            failures++;
            $display("[TB] FAIL normal_release_timing: got done at %0d release at %0d, expected one after last write",
                     done_cyc, rel_cyc);
        end
    endtask

    task automatic test_bad_header(input logic [7:0] lo, input logic [7:0] hi);
        do_reset();
        stream = '{lo, hi, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_load(0, 1, 50);
        run_model();
        checks++;
        if (error !== exp_error || cpu_reset !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL header_%h%h_state: got error=%b cpu_reset=%b done=%b expected error=%b cpu_reset=1 done=0",
                     hi, lo, error, cpu_reset, done, exp_error);
        end
        checks++;
        if (ack_cyc.size() != exp_acks || wr_data.size() != 0) begin
            failures++;
            $display("[TB] FAIL header_%h%h_traffic: got %0d acks %0d writes expected %0d acks 0 writes",
                     hi, lo, ack_cyc.size(), wr_data.size(), exp_acks);
        end
        checks++;
        if (ack_cyc.size() < 2 || err_cyc != ack_cyc[1]) begin
            failures++;
            $display("[TB] FAIL header_%h%h_error_timing: got error at %0d expected with second ack", hi, lo, err_cyc);
        end
    endtask

    task automatic test_full_size();
        do_reset();
        stream.push_back(8'h00);
        stream.push_back(8'h01);
        for (int i = 0; i < 4 * MAX_WORDS; i++) stream.push_back(8'($urandom));
        run_load(0, 0, 2400);
        run_model();
        checks++;
        if (wr_data.size() != MAX_WORDS || exp_words.size() != MAX_WORDS || write_mismatches() != 0) begin
            failures++;
            $display("[TB] FAIL full_size_writes: got %0d writes, %0d bad, expected %0d",
                     wr_data.size(), write_mismatches(), MAX_WORDS);
        end
        checks++;
        if (done !== 1'b1 || error !== 1'b0 || ack_cyc.size() != exp_acks) begin
            failures++;
            $display("[TB] FAIL full_size_final: got done=%b error=%b acks=%0d expected done=1 error=0 acks=%0d",
                     done, error, ack_cyc.size(), exp_acks);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        do_reset();
        c = int'($urandom_range(6, 1));
        stream.push_back(8'(c));
        stream.push_back(8'h00);
        for (int i = 0; i < 4 * c + 3; i++) stream.push_back(8'($urandom));
        run_load(0, 0, 120);
        run_model();
        checks++;
        if (dbl_clr != 0 || long_we != 0) begin
            failures++;
            $display("[TB] FAIL b2b_pulses: got %0d double ready_clr %0d long imem_we expected 0",
                     dbl_clr, long_we);
        end
        checks++;
        if (ack_cyc.size() != exp_acks || wr_data.size() != exp_words.size() || write_mismatches() != 0) begin
            failures++;
            $display("[TB] FAIL b2b_load: got %0d acks %0d writes expected %0d acks %0d writes",
                     ack_cyc.size(), wr_data.size(), exp_acks, exp_words.size());
        end
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_done: got done=%b cpu_reset=%b expected 1 0", done, cpu_reset);
        end
    endtask

    task automatic test_random_loads();
        int c, extra;
        for (int n = 0; n < 4; n++) begin
            do_reset();
            c     = int'($urandom_range(8, 1));
            extra = int'($urandom_range(3, 0));
            stream.push_back(8'(c));
            stream.push_back(8'h00);
            for (int i = 0; i < 4 * c + extra; i++) stream.push_back(8'($urandom));
            run_load(0, 3, 260);
            run_model();
            checks++;
            if (ack_cyc.size() != exp_acks || wr_data.size() != exp_words.size() ||
                write_mismatches() != 0 || done !== exp_done || dbl_clr != 0) begin
                failures++;
                $display("[TB] FAIL random_load_%0d: got acks=%0d writes=%0d bad=%0d done=%b expected acks=%0d writes=%0d done=%b",
                         n, ack_cyc.size(), wr_data.size(), write_mismatches(), done,
                         exp_acks, exp_words.size(), exp_done);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        stream = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        run_load(0, 0, 20);
        checks++;
        if (ack_cyc.size() != 4 || wr_data.size() != 0) begin
            failures++;
            $display("[TB] FAIL midword_partial: got %0d acks %0d writes expected 4 acks 0 writes",
                     ack_cyc.size(), wr_data.size());
        end
        reset = 1'b1;
        #1;
        checks++;
        if (cpu_reset !== 1'b1 || done !== 1'b0 || ready_clr !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midword_async_reset: got cpu_reset=%b done=%b ready_clr=%b expected 1 0 0",
                     cpu_reset, done, ready_clr);
        end
        do_reset();
        stream = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        run_load(0, 0, 40);
        run_model();
        checks++;
        if (wr_data.size() != 1 || wr_data[0] !== 32'h44332211 || wr_addr[0] !== '0 || write_mismatches() != 0) begin
            failures++;
            $display("[TB] FAIL midword_reload: got %0d writes first %h expected 1 write 44332211 at 0",
                     wr_data.size(), (wr_data.size() > 0) ? wr_data[0] : 32'h0);
        end
        checks++;
        if (done !== 1'b1 || cpu_reset !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midword_done: got done=%b cpu_reset=%b expected 1 0", done, cpu_reset);
        end
    endtask

    task automatic test_idle_traffic();
        do_reset();
        stream.push_back(8'h01);
        stream.push_back(8'h00);
        for (int i = 0; i < 4; i++) stream.push_back(8'($urandom));
        run_load(20, 0, 60);
        run_model();
        checks++;
        if (acks_before_enable != 0) begin
            failures++;
            $display("[TB] FAIL idle_acks: got %0d ready_clr pulses while idle expected 0", acks_before_enable);
        end
        checks++;
        if (ack_cyc.size() != exp_acks || wr_data.size() != 1 || write_mismatches() != 0 || done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL idle_then_load: got acks=%0d writes=%0d done=%b expected acks=%0d writes=1 done=1",
                     ack_cyc.size(), wr_data.size(), done, exp_acks);
        end
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_bad_header(8'h00, 8'h00);
        test_bad_header(8'h01, 8'h01);
        test_full_size();
        test_back_to_back();
        test_random_loads();
        test_reset_mid_word();
        test_idle_traffic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Boot-time controller between the memory-mapped UART receiver and the single-cycle CPU's instruction memory. While loading, it holds the CPU in reset. It takes bytes from the receiver with the `rx_ready`/`ready_clr` handshake and assembles them into 32-bit little-endian words, which it writes sequentially into instruction memory. After the last word it releases the CPU.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width.
- `MAX_WORDS`, 256: largest legal program length in words; must be ≤ 2^ADDR_W.

- `clk` input 1: system clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `enable` input 1: start request; sampled only in IDLE.
- `rx_ready` input 1: UART receiver holds a valid byte (level).
- `rx_data` input 8: received byte, valid while `rx_ready`=1.
- `ready_clr` output 1: one-cycle acknowledge to the receiver; the byte is consumed.
- `imem_we` output 1: instruction-memory write strobe.
- `imem_addr` output ADDR_W: word address of the write.
- `imem_wdata` output 32: word to write.
- `cpu_reset` output 1: holds the CPU in reset.
- `done` output 1: load completed; CPU running.
- `error` output 1: illegal header; load aborted.

## Operation
- States: IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERROR.
- Byte acceptance: a byte is accepted in cycle T only if all of the following hold:
  - the state is HDR0, HDR1 or DATA;
  - `rx_ready`=1;
  - `ready_clr`=0 in cycle T.
- On acceptance, `rx_data` is captured at the end of T and `ready_clr`=1 for exactly cycle T+1. A byte is never taken twice.
- IDLE → HDR0 when `enable`=1.
- HDR0: the accepted byte becomes count[7:0]. → HDR1.
- HDR1: the accepted byte becomes count[15:8], forming a 16-bit little-endian word count.
  - count=0 or count>MAX_WORDS → ERROR.
  - Otherwise → DATA, with byte index=0 and word index=0.
- DATA: the k-th accepted byte (k=0..3) goes to word bits [8k+7:8k]. After the 4th byte → WRITE.
- WRITE (one cycle):
  - `imem_we`=1, `imem_addr`=word index, `imem_wdata`=assembled word.
  - The word index increments and the byte index clears.
  - → DONE if the incremented index equals count; otherwise → DATA.
- In WRITE, `rx_ready` is not sampled. A pending byte waits for DATA.
- DONE: `cpu_reset`=0, `done`=1. It stays there until reset; `enable` and `rx_ready` are ignored.
- ERROR: `error`=1, `cpu_reset`=1. It stays there until reset; no further `ready_clr` pulses.
- `enable` deasserting after leaving IDLE has no effect.
- Bytes arriving in IDLE are neither acknowledged nor consumed.
- Word index width is ADDR_W+1, so count=2^ADDR_W compares without wrap. `imem_addr` carries the low ADDR_W bits.

## Timing
- Reset values:
  - `ready_clr`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0;
  - `cpu_reset`=1, `done`=0, `error`=0;
  - state=IDLE, all counters 0.
- All outputs are registered; no combinational path from any input to any output.
- A single-cycle `imem_we` pulse is registered from the fourth data byte. With that byte accepted in cycle T, `imem_we`=1 in cycle T+1.
- `cpu_reset` falls and `done` rises in the cycle after the final WRITE cycle.
- `error` rises in the cycle after the HDR1 byte is accepted.
- Back-to-back bytes (`rx_ready` held high, receiver clears one edge after `ready_clr`): at most one byte every 2 cycles.
- Reset asserted mid-load:
  - the FSM returns to IDLE immediately and a partial word is discarded;
  - memory words already written are not undone;
  - `cpu_reset` stays 1.

## Test plan
- Normal load: `enable`=1, then bytes 02 00, 78 56 34 12, EF BE AD DE. Required response:
  - writes (addr 0, 0x12345678) and (addr 1, 0xDEADBEEF);
  - exactly 10 `ready_clr` pulses;
  - `cpu_reset`=0 and `done`=1 one cycle after the second write.
- Zero count: header 00 00 → `error`=1 and `cpu_reset`=1. Further bytes get no `ready_clr` and produce no `imem_we`.
- Oversize count: header 01 01 (257) with MAX_WORDS=256 → ERROR state; header 00 01 (256) is accepted.
- Held `rx_ready`: receiver keeps `rx_ready`=1 through the ack cycle. Each byte is acknowledged once, and `ready_clr` is never high in two consecutive cycles.
- Reset mid-word: after header 01 00 and bytes AA BB, pulse `reset`, then `enable` with header 01 00 and bytes 11 22 33 44. Required response: a single write (addr 0, 0x44332211).
- Idle traffic: `rx_ready`=1 with `enable`=0 for 20 cycles → `ready_clr` stays 0; after `enable`, that byte is taken as HDR0.
